poly_basemul_ctrl: RTL and testbench
====================================

// Module: poly_basemul_ctrl
// PURPOSE
//  Upstream sequencer for basemul: walks two NTT-domain polynomials (128 coefficient pairs
//  each), fetches operands and the per-pair zeta, and drives basemul one pair at a time.
//  Collects r[0]/r[1] and writes the product polynomial back to result memory.
//  Sits between the NTT output buffers and the INTT/accumulate stage of the Kyber datapath.
// PARAMETERS
//  W        16   coefficient width (`KYBER_POLY_WIDTH), signed two's complement
//  NPAIRS   128  coefficient pairs per polynomial (n/2)
//  AW       7    pair address width, clog2(NPAIRS)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  start        in   1     1-cycle pulse: begin one polynomial product
//  busy         out  1     high from the cycle after start until done
//  done         out  1     1-cycle pulse after the last result write
//  ab_rd_en     out  1     read strobe, shared by the A and B memories
//  ab_addr      out  AW    pair index j; word = {c[2j+1], c[2j]}
//  a_rdata      in   2W    A pair; valid 1 cycle after ab_rd_en
//  b_rdata      in   2W    B pair; valid 1 cycle after ab_rd_en
//  zeta_addr    out  AW-1  zeta ROM index = j>>1 (ROM holds zetas[64..127])
//  zeta_rdata   in   W     valid 1 cycle after ab_rd_en (same timing as a/b)
//  bm_start     out  1     basemul_start, 1-cycle pulse
//  bm_a         out  2xW   {a1,a0} to basemul a[1:0]
//  bm_b         out  2xW   {b1,b0} to basemul b[1:0]
//  bm_zeta      out  W     zeta to basemul
//  bm_r         in   2xW   basemul r[1:0]
//  bm_r0_valid  in   1     r[0] valid strobe
//  bm_r1_valid  in   1     r[1] valid strobe (last)
//  r_we         out  1     result write strobe, 1 cycle
//  r_addr       out  AW    result pair index
//  r_wdata      out  2W    {r1,r0}
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE, j=0.
//   busy, done, ab_rd_en, bm_start and r_we = 0. All data/addr outputs = 0.
//  FSM: IDLE -start-> FETCH -> LOAD -> ISSUE -> WAIT -bm_r1_valid-> WRITE
//   WRITE -> FETCH (j<NPAIRS-1, j++). WRITE -> DONE (j==NPAIRS-1). DONE -> IDLE.
//  FETCH: ab_rd_en=1; ab_addr=j; zeta_addr=j[AW-1:1].
//  LOAD: register a_rdata/b_rdata into bm_a/bm_b.
//   bm_zeta = j[0] ? -zeta_rdata : zeta_rdata (W-bit wrap, no modular reduction).
//  ISSUE: bm_start=1 for exactly one cycle. bm_a/bm_b/bm_zeta held stable until WRITE ends.
//  WAIT: latch bm_r[0] on bm_r0_valid, bm_r[1] on bm_r1_valid.
//   Same-cycle r0/r1 valid: both latched. No cycle limit; stays until bm_r1_valid.
//   Valid strobes outside WAIT are ignored.
//  WRITE: r_we=1, r_addr=j, r_wdata={r1_lat,r0_lat}.
//  DONE: done=1 for one cycle, busy drops in the same cycle; j cleared.
//  busy=1 in FETCH..WRITE. start ignored when not IDLE. start in DONE is ignored.
//  Per-pair cycles = 4 + L, where L = ISSUE-to-r1_valid latency; total = 128*(4+L)+1.
//  Width rules: signed W-bit throughout; the controller does no arithmetic on results.
//  j wraps never: terminates at NPAIRS-1.
// TESTING (bench uses a behavioural basemul model with programmable latency L)
//  L=3, start once -> 128 r_we pulses, r_addr 0..127 in order.
//   done exactly 128*7+1 cycles after start; r_wdata matches the golden model each pair.
//  zeta_rdata=16'd2285 at j=0,1 -> bm_zeta=2285 (j=0), 16'hF713 (j=1); zeta_addr=0,0,1,1 for j=0..3.
//  Pair 0 A={59894,50360}, B={35686,21906} -> bm_a/bm_b are those exact values at bm_start.
//   Operands stay stable until r_we.
//  Model fires r0_valid and r1_valid in the same cycle -> r_wdata={r1,r0} correct, one write.
//  L=20 on pair 5 -> no r_we during the 20-cycle wait; second start pulse while busy -> ignored.
//  rst_n low at j=40 mid-WAIT -> outputs 0 immediately (async).
//   After release, new start -> begins at ab_addr=0; full 128-pair run completes.

Source files
------------

// File: rtl/poly_basemul_ctrl.sv
// poly_basemul_ctrl
//   Sequencer that walks two NTT-domain polynomials one coefficient pair at a
//   time. For each pair j it fetches A[j], B[j] and the zeta for that pair,
//   issues one basemul operation, collects r[0]/r[1] and writes {r1,r0} back to
//   result memory at index j. Sits between the NTT output buffers and the
//   INTT/accumulate stage.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle pulse, begins one polynomial product (IDLE only)
//   busy, done          busy over FETCH..WRITE; done pulses once at the end
//   ab_rd_en, ab_addr   shared read strobe/pair index for the A and B memories
//   a_rdata, b_rdata    operand pairs {c[2j+1],c[2j]}, valid 1 cycle after read
//   zeta_addr           zeta ROM index j>>1
//   zeta_rdata          zeta, same timing as a_rdata/b_rdata
//   bm_start            1-cycle issue pulse to basemul
//   bm_a, bm_b, bm_zeta basemul operands, held from LOAD through WRITE
//   bm_r                basemul result {r1,r0}
//   bm_r0_valid/r1      result strobes, sampled only while waiting
//   r_we, r_addr        result write strobe and pair index
//   r_wdata             {r1,r0}
module poly_basemul_ctrl #(
  parameter int W      = 16,
  parameter int NPAIRS = 128,
  parameter int AW     = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ab_rd_en,
  output logic [AW-1:0]   ab_addr,
  input  logic [2*W-1:0]  a_rdata,
  input  logic [2*W-1:0]  b_rdata,
  output logic [AW-2:0]   zeta_addr,
  input  logic [W-1:0]    zeta_rdata,
  output logic            bm_start,
  output logic [2*W-1:0]  bm_a,
  output logic [2*W-1:0]  bm_b,
  output logic [W-1:0]    bm_zeta,
  input  logic [2*W-1:0]  bm_r,
  input  logic            bm_r0_valid,
  input  logic            bm_r1_valid,
  output logic            r_we,
  output logic [AW-1:0]   r_addr,
  output logic [2*W-1:0]  r_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t                 state_q;
  logic [AW-1:0]          j_q, j_d;
  logic signed [W-1:0]    r0_q, r1_q, r0_d;
  logic                   busy_q, done_q, ab_rd_en_q, bm_start_q, r_we_q;
  logic [AW-1:0]          ab_addr_q, r_addr_q;
  logic [AW-2:0]          zeta_addr_q;
  logic [2*W-1:0]         bm_a_q, bm_b_q, r_wdata_q;
  logic signed [W-1:0]    bm_zeta_q;

  // Odd pairs of a zeta ROM entry use the negated zeta; plain W-bit wrap.
  function automatic logic signed [W-1:0] cond_neg(input logic signed [W-1:0] z,
                                                   input logic               neg);
    return neg ? -z : z;
  endfunction

  assign j_d  = j_q + 1'b1;
  // r0 may arrive in the same cycle as r1, so the write data takes it directly.
  assign r0_d = bm_r0_valid ? bm_r[W-1:0] : r0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ab_rd_en_q  <= 1'b0;
      bm_start_q  <= 1'b0;
      r_we_q      <= 1'b0;
      ab_addr_q   <= '0;
      r_addr_q    <= '0;
      zeta_addr_q <= '0;
      bm_a_q      <= '0;
      bm_b_q      <= '0;
      bm_zeta_q   <= '0;
      r_wdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FETCH;
            busy_q      <= 1'b1;
            ab_rd_en_q  <= 1'b1;
            ab_addr_q   <= j_q;
            zeta_addr_q <= j_q[AW-1:1];
          end
        end
        S_FETCH: begin
          ab_rd_en_q <= 1'b0;
          state_q    <= S_LOAD;
        end
        S_LOAD: begin
          bm_a_q     <= a_rdata;
          bm_b_q     <= b_rdata;
          bm_zeta_q  <= cond_neg(zeta_rdata, j_q[0]);
          bm_start_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          bm_start_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          r0_q <= r0_d;
          if (bm_r1_valid) begin
            r1_q      <= bm_r[2*W-1:W];
            r_wdata_q <= {bm_r[2*W-1:W], r0_d};
            r_we_q    <= 1'b1;
            r_addr_q  <= j_q;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_we_q <= 1'b0;
          if (j_q == AW'(NPAIRS - 1)) begin
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            j_q         <= j_d;
            ab_rd_en_q  <= 1'b1;
            ab_addr_q   <= j_d;
            zeta_addr_q <= j_d[AW-1:1];
            state_q     <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ab_rd_en  = ab_rd_en_q;
  assign ab_addr   = ab_addr_q;
  assign zeta_addr = zeta_addr_q;
  assign bm_start  = bm_start_q;
  assign bm_a      = bm_a_q;
  assign bm_b      = bm_b_q;
  assign bm_zeta   = bm_zeta_q;
  assign r_we      = r_we_q;
  assign r_addr    = r_addr_q;
  assign r_wdata   = r_wdata_q;

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Testbench for poly_basemul_ctrl: memory/ROM models, a behavioural basemul
// with programmable latency, a monitor checking every fetch/issue/write, and a
// table of full-polynomial runs plus hand-written corner-case sequences.
module tb_poly_basemul_ctrl;
  localparam int W = 16, NPAIRS = 128, AW = 7;

  logic            clk, rst_n, start;
  logic            busy, done, ab_rd_en, bm_start, r_we;
  logic [AW-1:0]   ab_addr, r_addr;
  logic [AW-2:0]   zeta_addr;
  logic [2*W-1:0]  a_rdata, b_rdata, bm_a, bm_b, bm_r, r_wdata;
  logic [W-1:0]    zeta_rdata, bm_zeta;
  logic            bm_r0_valid, bm_r1_valid;

  poly_basemul_ctrl #(.W(W), .NPAIRS(NPAIRS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ab_rd_en(ab_rd_en), .ab_addr(ab_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .zeta_addr(zeta_addr), .zeta_rdata(zeta_rdata), .bm_start(bm_start),
    .bm_a(bm_a), .bm_b(bm_b), .bm_zeta(bm_zeta), .bm_r(bm_r),
    .bm_r0_valid(bm_r0_valid), .bm_r1_valid(bm_r1_valid),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2*W-1:0] amem [NPAIRS];
  logic [2*W-1:0] bmem [NPAIRS];
  logic [W-1:0]   zrom [NPAIRS/2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [2*W-1:0] bm_func(input logic [2*W-1:0] a,
                                             input logic [2*W-1:0] b,
                                             input logic [W-1:0]   z);
    logic [W-1:0] a0, a1, b0, b1, r0, r1;
    a0 = a[W-1:0]; a1 = a[2*W-1:W];
    b0 = b[W-1:0]; b1 = b[2*W-1:W];
    r0 = a0 * b0 + a1 * b1 * z;
    r1 = a0 * b1 + a1 * b0;
    return {r1, r0};
  endfunction

  function automatic logic [W-1:0] zeta_for(input int j);
    logic [W-1:0] z;
    z = zrom[j / 2];
    return (j % 2 == 1) ? (16'd0 - z) : z;
  endfunction

  function automatic logic [2*W-1:0] gold(input int j);
    return bm_func(amem[j], bmem[j], zeta_for(j));
  endfunction

  task automatic rand_mem();
    for (int i = 0; i < NPAIRS; i++) begin
      amem[i] = $urandom;
      bmem[i] = $urandom;
    end
    for (int i = 0; i < NPAIRS/2; i++) zrom[i] = W'($urandom);
    amem[0] = {16'd59894, 16'd50360};
    bmem[0] = {16'd35686, 16'd21906};
    zrom[0] = 16'd2285;
  endtask

  // ---------------- memory / ROM model (1-cycle read latency) ----------------
  logic           mem_rd;
  logic [AW-1:0]  mem_ad;
  logic [AW-2:0]  mem_za;
  initial begin
    a_rdata = '0; b_rdata = '0; zeta_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rd = ab_rd_en; mem_ad = ab_addr; mem_za = zeta_addr;
      #1;
      if (mem_rd) begin
        a_rdata    = amem[mem_ad];
        b_rdata    = bmem[mem_ad];
        zeta_rdata = zrom[mem_za];
      end else begin
        a_rdata    = $urandom;
        b_rdata    = $urandom;
        zeta_rdata = W'($urandom);
      end
    end
  end

  // ---------------- behavioural basemul ----------------
  int             lat_cfg = 3, lat_ovr_pair = -1, lat_ovr = 0, m_lat = 0;
  bit             same_cyc = 1'b0, spur_en = 1'b0;
  int             m_cd = -1, m_idx = 0;
  logic [2*W-1:0] m_res;
  initial begin
    bm_r = '0; bm_r0_valid = 1'b0; bm_r1_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      bm_r0_valid = 1'b0;
      bm_r1_valid = 1'b0;
      bm_r        = $urandom;
      if (!rst_n) begin
        m_cd = -1;
      end else begin
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 1 && !same_cyc) begin
            bm_r0_valid = 1'b1;
            bm_r        = {W'($urandom), m_res[W-1:0]};
          end
          if (m_cd == 0) begin
            bm_r1_valid = 1'b1;
            if (same_cyc || m_lat < 2) begin
              bm_r0_valid = 1'b1;
              bm_r        = m_res;
            end else begin
              bm_r = {m_res[2*W-1:W], W'($urandom)};
            end
            m_cd = -1;
          end
        end else if (spur_en && !bm_start && $urandom_range(0, 5) == 0) begin
          // stray strobes carrying junk while the controller is not waiting
          bm_r0_valid = 1'($urandom_range(0, 1));
          bm_r1_valid = 1'b1;
        end
        if (bm_start) begin
          m_lat = (m_idx == lat_ovr_pair) ? lat_ovr : lat_cfg;
          m_res = bm_func(bm_a, bm_b, bm_zeta);
          m_cd  = m_lat;
          m_idx++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit             mon_en = 1'b0, holding = 1'b0;
  int             f_idx, i_idx, w_idx, stab_bad, early_wr;
  logic [W-1:0]   zeta_seen [2];
  logic [AW-2:0]  za_seen [4];
  logic [2*W-1:0] a0_seen, b0_seen, hold_a, hold_b;
  logic [W-1:0]   hold_z;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ab_rd_en) begin
        chk("ab_addr", ab_addr, f_idx % NPAIRS);
        chk("zeta_addr", zeta_addr, (f_idx % NPAIRS) / 2);
        if (f_idx < 4) za_seen[f_idx] = zeta_addr;
        f_idx++;
      end
      if (bm_start) begin
        chk("bm_a", bm_a, amem[i_idx % NPAIRS]);
        chk("bm_b", bm_b, bmem[i_idx % NPAIRS]);
        chk("bm_zeta", bm_zeta, zeta_for(i_idx % NPAIRS));
        if (i_idx < 2) zeta_seen[i_idx] = bm_zeta;
        if (i_idx == 0) begin a0_seen = bm_a; b0_seen = bm_b; end
        hold_a = bm_a; hold_b = bm_b; hold_z = bm_zeta;
        holding = 1'b1; stab_bad = 0;
        i_idx++;
      end else if (holding) begin
        if (bm_a !== hold_a || bm_b !== hold_b || bm_zeta !== hold_z) stab_bad++;
      end
      if (r_we) begin
        if (m_cd > 0) early_wr++;
        chk("r_addr", r_addr, w_idx % NPAIRS);
        chk("r_wdata", r_wdata, gold(w_idx % NPAIRS));
        chk("operand_hold", stab_bad, 0);
        holding = 1'b0;
        w_idx++;
      end
    end
  end

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ab_rd_en"}, ab_rd_en, 0);
    chk({nm, "_bm_start"}, bm_start, 0);
    chk({nm, "_r_we"}, r_we, 0);
    chk({nm, "_addrs"}, {ab_addr, zeta_addr, r_addr}, 0);
    chk({nm, "_bm_ab"}, {bm_a, bm_b}, 0);
    chk({nm, "_zeta_wdata"}, {bm_zeta, r_wdata}, 0);
  endtask

  // One polynomial product. restart_cyc pulses start again mid-run;
  // abort_pair >= 0 pulls rst_n low while that pair is waiting for results.
  task automatic run_poly(input string nm, input int lat, input bit same, input bit spur,
                          input int exp_cyc, input int ovr_pair, input int ovr_lat,
                          input int restart_cyc, input int abort_pair);
    int cyc, busy_cyc, idle_bad;
    bit got_done;
    lat_cfg = lat; same_cyc = same; spur_en = spur;
    lat_ovr_pair = ovr_pair; lat_ovr = ovr_lat;
    f_idx = 0; i_idx = 0; w_idx = 0; m_idx = 0; early_wr = 0; stab_bad = 0;
    holding = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b1;
    cyc = 0; busy_cyc = 0; got_done = 1'b0;
    while (!got_done && cyc < 6000) begin
      @(posedge clk); #2;
      cyc++;
      start = (cyc == restart_cyc);
      if (busy) busy_cyc++;
      if (abort_pair >= 0 && m_idx == abort_pair + 1 && m_cd > 0 && !bm_start) begin
        mon_en = 1'b0;
        start  = 1'b0;
        chk({nm, "_busy_before_rst"}, busy, 1);
        chk({nm, "_pair_at_rst"}, f_idx, abort_pair + 1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outs(nm);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        return;
      end
      if (done) got_done = 1'b1;
    end
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_busy_cycles"}, busy_cyc, exp_cyc - 1);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_writes"}, w_idx, NPAIRS);
    chk({nm, "_fetches"}, f_idx, NPAIRS);
    chk({nm, "_issues"}, i_idx, NPAIRS);
    chk({nm, "_early_writes"}, early_wr, 0);
    // start presented during DONE must not launch another product
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk({nm, "_done_one_cycle"}, done, 0);
    idle_bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy || ab_rd_en || bm_start || r_we) idle_bad++;
      @(posedge clk); #2;
    end
    chk({nm, "_idle_after_done"}, idle_bad, 0);
  endtask

  typedef struct {
    string name;
    int    lat;
    bit    same;
    bit    spur;
    int    exp_cyc;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the test finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name: "L3",      lat: 3, same: 1'b0, spur: 1'b0, exp_cyc: 897};
    vecs[1] = '{name: "L1",      lat: 1, same: 1'b0, spur: 1'b1, exp_cyc: 641};
    vecs[2] = '{name: "L2_same", lat: 2, same: 1'b1, spur: 1'b0, exp_cyc: 769};
    vecs[3] = '{name: "L6_spur", lat: 6, same: 1'b0, spur: 1'b1, exp_cyc: 1281};

    start = 1'b0;
    rst_n = 1'b1;
    rand_mem();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_reset_outs("reset");
    #2 rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      rand_mem();
      run_poly(vecs[v].name, vecs[v].lat, vecs[v].same, vecs[v].spur,
               vecs[v].exp_cyc, -1, 0, -1, -1);
      if (v == 0) begin
        chk("zeta_j0", zeta_seen[0], 16'd2285);
        chk("zeta_j1", zeta_seen[1], 16'hF713);
        chk("zaddr_j0", za_seen[0], 0);
        chk("zaddr_j1", za_seen[1], 0);
        chk("zaddr_j2", za_seen[2], 1);
        chk("zaddr_j3", za_seen[3], 1);
        chk("pair0_a", a0_seen, {16'd59894, 16'd50360});
        chk("pair0_b", b0_seen, {16'd35686, 16'd21906});
      end
    end

    // pair 5 takes 20 cycles; a second start arrives during that wait
    rand_mem();
    run_poly("L20_pair5", 3, 1'b0, 1'b0, 914, 5, 20, 50, -1);

    // asynchronous reset while pair 40 waits, then a clean full run
    rand_mem();
    run_poly("abort", 5, 1'b0, 1'b0, 0, -1, 0, -1, 40);
    run_poly("after_rst", 3, 1'b0, 1'b0, 897, -1, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
